// File: rtl/vproc_arb_pkg.sv
// Shared types and widths for the VProc64 bus arbiter.
// Bus slice widths are per master; packed buses use master i at [i*W +: W].
package vproc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        FLUSH
    } arb_state_e;

    localparam int IDX_W       = 3;
    localparam int MAX_MASTERS = 8;
    localparam int TO_CNT_W    = 16;

    localparam int ADDR_W  = 64;
    localparam int BE_W    = 8;
    localparam int BURST_W = 12;

endpackage

// File: rtl/vproc_rr_select.sv
// Combinational round-robin pick: first requester after the last winner.
module vproc_rr_select
    import vproc_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    output logic [IDX_W-1:0]       winner,
    output logic                   valid
);

    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        // k == NUM_MASTERS wraps back to the last winner itself
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(last) + k) % NUM_MASTERS;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/vproc_bus_arbiter.sv
// Round-robin arbiter sharing one 64-bit VProc slave among VProc64 masters,
// holding grants across bursts, with a watchdog that flushes silent slaves.
module vproc_bus_arbiter
    import vproc_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                            Clk,
    input  logic                            nReset,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   M_Addr,
    input  logic [NUM_MASTERS*BE_W-1:0]     M_BE,
    input  logic [NUM_MASTERS-1:0]          M_WE,
    input  logic [NUM_MASTERS-1:0]          M_RD,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   M_DataOut,
    input  logic [NUM_MASTERS*BURST_W-1:0]  M_Burst,
    input  logic [NUM_MASTERS-1:0]          M_BurstFirst,
    input  logic [NUM_MASTERS-1:0]          M_BurstLast,
    output logic [ADDR_W-1:0]               M_DataIn,
    output logic [NUM_MASTERS-1:0]          M_WRAck,
    output logic [NUM_MASTERS-1:0]          M_RDAck,
    output logic [ADDR_W-1:0]               S_Addr,
    output logic [BE_W-1:0]                 S_BE,
    output logic                            S_WE,
    output logic                            S_RD,
    output logic [ADDR_W-1:0]               S_DataOut,
    output logic [BURST_W-1:0]              S_Burst,
    output logic                            S_BurstFirst,
    output logic                            S_BurstLast,
    input  logic [ADDR_W-1:0]               S_DataIn,
    input  logic                            S_WRAck,
    input  logic                            S_RDAck,
    output logic [NUM_MASTERS-1:0]          Grant,
    output logic                            TimeoutErr,
    output logic [IDX_W-1:0]                TimeoutMaster,
    input  logic                            ClrErr
);

    arb_state_e state, state_nxt;

    logic [IDX_W-1:0]       owner, owner_nxt;
    logic [IDX_W-1:0]       last, last_nxt;
    logic [IDX_W-1:0]       pick;
    logic                   pick_valid;
    logic [TO_CNT_W-1:0]    wd_cnt, wd_cnt_nxt;
    logic                   err_nxt;
    logic [IDX_W-1:0]       tmaster_nxt;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] owner_oh;

    logic [ADDR_W-1:0]  o_addr;
    logic [ADDR_W-1:0]  o_data;
    logic [BE_W-1:0]    o_be;
    logic [BURST_W-1:0] o_burst;
    logic               o_rd;
    logic               o_we;
    logic               o_first;
    logic               o_last;
    logic               o_ack;
    logic               o_end;
    logic               wd_fire;

    assign req = M_RD | M_WE;

    vproc_rr_select #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_rr_select (
        .req   (req),
        .last  (last),
        .winner(pick),
        .valid (pick_valid)
    );

    always_comb begin
        o_addr   = '0;
        o_data   = '0;
        o_be     = '0;
        o_burst  = '0;
        o_rd     = 1'b0;
        o_we     = 1'b0;
        o_first  = 1'b0;
        o_last   = 1'b0;
        owner_oh = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner == IDX_W'(i)) begin
                owner_oh[i] = 1'b1;
                o_addr      = M_Addr[i*ADDR_W +: ADDR_W];
                o_data      = M_DataOut[i*ADDR_W +: ADDR_W];
                o_be        = M_BE[i*BE_W +: BE_W];
                o_burst     = M_Burst[i*BURST_W +: BURST_W];
                o_rd        = M_RD[i];
                o_we        = M_WE[i];
                o_first     = M_BurstFirst[i];
                o_last      = M_BurstLast[i];
            end
        end
    end

    assign o_ack   = (S_RDAck & o_rd) | (S_WRAck & o_we);
    assign o_end   = (o_burst == '0) || o_last;
    assign wd_fire = (TIMEOUT_CYCLES != 0) &&
                     ((int'(wd_cnt) + 1) == TIMEOUT_CYCLES);

    always_comb begin
        S_Addr       = '0;
        S_BE         = '0;
        S_DataOut    = '0;
        S_Burst      = '0;
        S_BurstFirst = 1'b0;
        S_BurstLast  = 1'b0;
        S_RD         = 1'b0;
        S_WE         = 1'b0;
        Grant        = '0;
        M_RDAck      = '0;
        M_WRAck      = '0;
        M_DataIn     = S_DataIn;
        unique case (state)
            OWN: begin
                S_Addr       = o_addr;
                S_BE         = o_be;
                S_DataOut    = o_data;
                S_Burst      = o_burst;
                S_BurstFirst = o_first;
                S_BurstLast  = o_last;
                S_RD         = o_rd;
                S_WE         = o_we;
                Grant        = owner_oh;
                M_RDAck      = owner_oh & {NUM_MASTERS{S_RDAck & o_rd}};
                M_WRAck      = owner_oh & {NUM_MASTERS{S_WRAck & o_we}};
            end
            FLUSH: begin
                // slave is cut off; the owner is drained with zero data
                S_Addr       = o_addr;
                S_BE         = o_be;
                S_DataOut    = o_data;
                S_Burst      = o_burst;
                S_BurstFirst = o_first;
                S_BurstLast  = o_last;
                Grant        = owner_oh;
                M_DataIn     = '0;
                M_RDAck      = owner_oh & {NUM_MASTERS{o_rd}};
                M_WRAck      = owner_oh & {NUM_MASTERS{o_we}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        last_nxt    = last;
        wd_cnt_nxt  = wd_cnt;
        err_nxt     = TimeoutErr & ~ClrErr;
        tmaster_nxt = TimeoutMaster;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt  = OWN;
                    owner_nxt  = pick;
                    last_nxt   = pick;
                    wd_cnt_nxt = '0;
                end
            end
            OWN: begin
                if (!(o_rd || o_we)) begin
                    state_nxt = IDLE;
                end else if (o_ack) begin
                    wd_cnt_nxt = '0;
                    if (o_end) begin
                        state_nxt = IDLE;
                    end
                end else if (wd_fire) begin
                    state_nxt   = FLUSH;
                    err_nxt     = 1'b1;
                    tmaster_nxt = owner;
                    wd_cnt_nxt  = '0;
                end else begin
                    wd_cnt_nxt = wd_cnt + TO_CNT_W'(1);
                end
            end
            FLUSH: begin
                if (!(o_rd || o_we) || o_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state         <= IDLE;
            owner         <= '0;
            last          <= IDX_W'(NUM_MASTERS - 1);
            wd_cnt        <= '0;
            TimeoutErr    <= 1'b0;
            TimeoutMaster <= '0;
        end else begin
            state         <= state_nxt;
            owner         <= owner_nxt;
            last          <= last_nxt;
            wd_cnt        <= wd_cnt_nxt;
            TimeoutErr    <= err_nxt;
            TimeoutMaster <= tmaster_nxt;
        end
    end

endmodule

// File: tb/tb_vproc_bus_arbiter.sv
// Scoreboard bench: masters and slave modelled in the bench, expected
// per-beat responses queued in round-robin order and checked on every ack.
module tb_vproc_bus_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic            Clk = 1'b0;
    logic            nReset;
    logic [N*64-1:0] M_Addr;
    logic [N*8-1:0]  M_BE;
    logic [N-1:0]    M_WE;
    logic [N-1:0]    M_RD;
    logic [N*64-1:0] M_DataOut;
    logic [N*12-1:0] M_Burst;
    logic [N-1:0]    M_BurstFirst;
    logic [N-1:0]    M_BurstLast;
    logic [63:0]     M_DataIn;
    logic [N-1:0]    M_WRAck;
    logic [N-1:0]    M_RDAck;
    logic [63:0]     S_Addr;
    logic [7:0]      S_BE;
    logic            S_WE;
    logic            S_RD;
    logic [63:0]     S_DataOut;
    logic [11:0]     S_Burst;
    logic            S_BurstFirst;
    logic            S_BurstLast;
    logic [63:0]     S_DataIn;
    logic            S_WRAck;
    logic            S_RDAck;
    logic [N-1:0]    Grant;
    logic            TimeoutErr;
    logic [2:0]      TimeoutMaster;
    logic            ClrErr;

    vproc_bus_arbiter #(
        .NUM_MASTERS(N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk(Clk), .nReset(nReset),
        .M_Addr(M_Addr), .M_BE(M_BE), .M_WE(M_WE), .M_RD(M_RD),
        .M_DataOut(M_DataOut), .M_Burst(M_Burst),
        .M_BurstFirst(M_BurstFirst), .M_BurstLast(M_BurstLast),
        .M_DataIn(M_DataIn), .M_WRAck(M_WRAck), .M_RDAck(M_RDAck),
        .S_Addr(S_Addr), .S_BE(S_BE), .S_WE(S_WE), .S_RD(S_RD),
        .S_DataOut(S_DataOut), .S_Burst(S_Burst),
        .S_BurstFirst(S_BurstFirst), .S_BurstLast(S_BurstLast),
        .S_DataIn(S_DataIn), .S_WRAck(S_WRAck), .S_RDAck(S_RDAck),
        .Grant(Grant), .TimeoutErr(TimeoutErr),
        .TimeoutMaster(TimeoutMaster), .ClrErr(ClrErr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          m;
        logic        rd;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [7:0]  be;
        logic        flush;
    } beat_t;

    beat_t exp_q[$];
    beat_t me;
    logic [N-1:0] oh;

    logic        mact[N];
    logic        trd[N];
    logic        twe[N];
    int          tbeat[N];
    int          tburst[N];
    logic [63:0] tbase[N];
    logic [63:0] tseed[N];
    logic [7:0]  tbe[N];
    logic        acked[N];

    int          model_last;
    logic        slave_silent;
    logic        ovr_en;
    logic [63:0] ovr_val;
    int          stall;
    int          npass;
    int          ntotal;

    function automatic logic [63:0] rdata_fn(input logic [63:0] a);
        return {a[31:0], ~a[31:0]} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [N-1:0] active_mask();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i] = mact[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        ntotal++;
        if (got === want) npass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    always_comb begin
        M_Addr       = '0;
        M_BE         = '0;
        M_WE         = '0;
        M_RD         = '0;
        M_DataOut    = '0;
        M_Burst      = '0;
        M_BurstFirst = '0;
        M_BurstLast  = '0;
        for (int i = 0; i < N; i++) begin
            M_RD[i]              = mact[i] & trd[i];
            M_WE[i]              = mact[i] & twe[i];
            M_Addr[i*64 +: 64]   = tbase[i] + 64'(8 * tbeat[i]);
            M_BE[i*8 +: 8]       = tbe[i];
            M_DataOut[i*64 +: 64] = tseed[i] + 64'(tbeat[i]);
            M_Burst[i*12 +: 12]  = 12'(tburst[i]);
            M_BurstFirst[i]      = mact[i] && (tbeat[i] == 0);
            M_BurstLast[i]       = mact[i] && (tburst[i] != 0) &&
                                   (tbeat[i] == tburst[i] - 1);
        end
    end

    task automatic post(input int m, input logic rd, input logic we,
                        input int burst);
        tbase[m]  = {$urandom, $urandom} & ~64'h7;
        tseed[m]  = {$urandom, $urandom};
        tbe[m]    = 8'($urandom);
        trd[m]    = rd;
        twe[m]    = we;
        tburst[m] = burst;
        tbeat[m]  = 0;
        mact[m]   = 1'b1;
    endtask

    task automatic push_txn(input int m, input logic flush);
        beat_t b;
        int nb;
        nb = (tburst[m] == 0) ? 1 : tburst[m];
        for (int k = 0; k < nb; k++) begin
            b.m     = m;
            b.rd    = trd[m];
            b.we    = twe[m];
            b.addr  = tbase[m] + 64'(8 * k);
            b.wdata = tseed[m] + 64'(k);
            b.be    = tbe[m];
            b.flush = flush;
            b.rdata = flush ? 64'h0 : (ovr_en ? ovr_val : rdata_fn(b.addr));
            exp_q.push_back(b);
        end
    endtask

    // Pending masters are served once each, scanning cyclically after the last winner.
    task automatic model_push(input logic [N-1:0] mask, input logic flush);
        int idx;
        int lastw;
        lastw = model_last;
        for (int k = 1; k <= N; k++) begin
            idx = (model_last + k) % N;
            if (mask[idx]) begin
                push_txn(idx, flush);
                lastw = idx;
            end
        end
        model_last = lastw;
    endtask

    task automatic cycle();
        @(negedge Clk);
        for (int i = 0; i < N; i++) begin
            if (acked[i]) begin
                if (tburst[i] == 0 || tbeat[i] == tburst[i] - 1) mact[i] = 1'b0;
                else tbeat[i]++;
                acked[i] = 1'b0;
            end
        end
        #1;
        S_RDAck  = 1'b0;
        S_WRAck  = 1'b0;
        S_DataIn = {$urandom, $urandom};
        if (!slave_silent && (S_RD || S_WE)) begin
            if (stall < 2 && $urandom_range(0, 2) == 0) begin
                stall++;
            end else begin
                stall    = 0;
                S_RDAck  = S_RD;
                S_WRAck  = S_WE;
                S_DataIn = ovr_en ? ovr_val : rdata_fn(S_Addr);
            end
        end
        #1;
        for (int i = 0; i < N; i++) acked[i] = M_RDAck[i] | M_WRAck[i];
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (active_mask() != '0 && n < 300) begin
            cycle();
            n++;
        end
        chk("drain", 64'(active_mask()), 64'h0);
        for (int i = 0; i < N; i++) mact[i] = 1'b0;
    endtask

    always @(negedge Clk) begin
        #3;
        if ((|M_RDAck) || (|M_WRAck)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 64'({M_RDAck, M_WRAck}), 64'h0);
            end else begin
                me = exp_q.pop_front();
                oh = N'(1) << me.m;
                chk("grant", 64'(Grant), 64'(oh));
                chk("rdack", 64'(M_RDAck), me.rd ? 64'(oh) : 64'h0);
                chk("wrack", 64'(M_WRAck), me.we ? 64'(oh) : 64'h0);
                if (me.rd) chk("rdata", M_DataIn, me.rdata);
                if (me.flush) begin
                    chk("flush_strobes", 64'({S_RD, S_WE}), 64'h0);
                end else begin
                    chk("s_addr", S_Addr, me.addr);
                    chk("s_be", 64'(S_BE), 64'(me.be));
                    chk("s_strobes", 64'({S_RD, S_WE}), 64'({me.rd, me.we}));
                    if (me.we) chk("s_wdata", S_DataOut, me.wdata);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int sel;
        logic [N-1:0] mask;
        npass = 0; ntotal = 0; model_last = N - 1;
        slave_silent = 1'b0; ovr_en = 1'b0; ovr_val = '0; stall = 0;
        ClrErr = 1'b0; S_RDAck = 1'b0; S_WRAck = 1'b0; S_DataIn = '0;
        for (int i = 0; i < N; i++) begin
            mact[i] = 1'b0; trd[i] = 1'b0; twe[i] = 1'b0; tbeat[i] = 0;
            tburst[i] = 0; tbase[i] = '0; tseed[i] = '0; tbe[i] = '0;
            acked[i] = 1'b0;
        end
        nReset = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_grant", 64'(Grant), 64'h0);
        chk("rst_strobes", 64'({S_RD, S_WE}), 64'h0);
        chk("rst_err", 64'(TimeoutErr), 64'h0);
        chk("rst_tmaster", 64'(TimeoutMaster), 64'h0);
        chk("rst_acks", 64'({M_RDAck, M_WRAck}), 64'h0);
        nReset = 1'b1;
        cycle();

        post(0, 1'b1, 1'b0, 0);
        post(1, 1'b1, 1'b0, 0);
        model_push(4'b0011, 1'b0);
        cycle();
        chk("t1_first_grant", 64'(Grant), 64'h1);
        wait_idle();

        post(2, 1'b0, 1'b1, 4);
        model_push(4'b0100, 1'b0);
        cycle();
        chk("t2_burst_grant", 64'(Grant), 64'h4);
        post(0, 1'b1, 1'b0, 0);
        model_push(4'b0001, 1'b0);
        for (int n = 0; n < 100 && mact[2]; n++) cycle();
        chk("t2_bubble_grant", 64'(Grant), 64'h0);
        chk("t2_bubble_strobes", 64'({S_RD, S_WE}), 64'h0);
        cycle();
        chk("t2_next_grant", 64'(Grant), 64'h1);
        wait_idle();

        for (int i = 0; i < N; i++) post(i, 1'b1, 1'b0, 0);
        model_push(4'b1111, 1'b0);
        wait_idle();

        ovr_en  = 1'b1;
        ovr_val = 64'hCAFE_F00D_1234_5678;
        post(1, 1'b1, 1'b0, 0);
        model_push(4'b0010, 1'b0);
        wait_idle();
        ovr_en = 1'b0;

        for (int r = 0; r < 40; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    sel = $urandom_range(0, 2);
                    post(i, sel != 1, sel != 0, $urandom_range(0, 3));
                end
            end
            model_push(mask, 1'b0);
            wait_idle();
        end

        slave_silent = 1'b1;
        post(3, 1'b1, 1'b0, 2);
        model_push(4'b1000, 1'b1);
        cycle();
        chk("t5_grant", 64'(Grant), 64'h8);
        repeat (TO - 1) cycle();
        chk("t5_no_early_err", 64'(TimeoutErr), 64'h0);
        cycle();
        chk("t5_err_set", 64'(TimeoutErr), 64'h1);
        chk("t5_tmaster", 64'(TimeoutMaster), 64'h3);
        wait_idle();
        chk("t5_err_sticky", 64'(TimeoutErr), 64'h1);
        ClrErr = 1'b1;
        cycle();
        ClrErr = 1'b0;
        chk("t5_err_clr", 64'(TimeoutErr), 64'h0);

        post(1, 1'b0, 1'b1, 4);
        repeat (3) cycle();
        chk("t6_grant_before", 64'(Grant), 64'h2);
        nReset = 1'b0;
        #1;
        chk("t6_rst_grant", 64'(Grant), 64'h0);
        chk("t6_rst_acks", 64'({M_RDAck, M_WRAck}), 64'h0);
        chk("t6_rst_strobe", 64'({S_RD, S_WE}), 64'h0);
        for (int i = 0; i < N; i++) begin
            mact[i]  = 1'b0;
            acked[i] = 1'b0;
        end
        repeat (2) cycle();
        nReset = 1'b1;
        model_last   = N - 1;
        slave_silent = 1'b0;
        post(1, 1'b1, 1'b0, 0);
        post(2, 1'b1, 1'b0, 0);
        post(0, 1'b1, 1'b0, 0);
        model_push(4'b0111, 1'b0);
        cycle();
        chk("t6_first_after_rst", 64'(Grant), 64'h1);
        wait_idle();
        repeat (2) cycle();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
